regfile_nr1w: RTL and testbench
===============================

Name: regfile_nr1w

Overview:
- Parametrised register file with one write port and NREAD independent registered read ports.
- Generalises the 64-bit 32:1 register-read mux to configurable width, depth and read-port count.
- Adds storage, a hard-wired zero register (ARM XZR), write-to-read bypass and per-port read-valid.
- Sits between the decode stage (register addresses) and the ALU operand latches in the datapath.

Parameters:
WIDTH, 64, data bits per register.
DEPTH, 32, number of registers; any value of 2 or more, not necessarily a power of two.
NREAD, 2, number of read ports, 1 to 4.
ZERO_REG, 1, when 1 register ZERO_IDX always reads 0 and ignores writes.
ZERO_IDX, 31, index of the zero register; must be below DEPTH.
BYPASS, 1, when 1 a same-cycle write to the read address is forwarded to the read.
AW (derived localparam), $clog2(DEPTH), address width.

Ports:
clk  input  1  single clock; all state updates on its rising edge.
reset  input  1  one clock; reset is synchronous and active-low (reset==0 at a rising clk edge resets the block).
wr_en  input  1  write request this cycle.
wr_addr  input  AW  write register index.
wr_data  input  WIDTH  write data.
rd_en  input  NREAD  per-port read request.
rd_addr  input  NREAD x AW  per-port read index, packed [NREAD-1:0][AW-1:0].
rd_data  output  NREAD x WIDTH  per-port read data, packed [NREAD-1:0][WIDTH-1:0].
rd_valid  output  NREAD  per-port: rd_data was updated by the previous edge.

Behaviour:
- Reset (reset==0 at an edge): all DEPTH registers become 0; every rd_data becomes 0; every rd_valid becomes 0.
  - Reset overrides any wr_en or rd_en sampled at the same edge.
  - A write coincident with reset is lost.
- Effective write condition: wr_en==1, wr_addr<DEPTH, and not (ZERO_REG==1 and wr_addr==ZERO_IDX).
  - When the condition holds, the register is updated at the edge.
  - Otherwise storage is unchanged; the write is not flagged.
- Read latency is 1 cycle. If rd_en[p]==1 at edge N:
  - rd_data[p] is loaded at edge N.
  - rd_valid[p]=1 during cycle N+1.
- rd_data[p] value selection, in priority order:
  1. 0 if rd_addr[p]>=DEPTH.
  2. 0 if ZERO_REG==1 and rd_addr[p]==ZERO_IDX.
  3. wr_data if BYPASS==1 and an effective write targets rd_addr[p] at the same edge.
  4. Otherwise the stored value before that edge.
- With BYPASS==0, a same-edge read returns the old value; the new value is visible from the next read onward.
- rd_en[p]==0 at an edge: rd_data[p] holds its previous value; rd_valid[p]=0.
- Ports are fully independent:
  - Any number of ports may read the same address in the same cycle; all receive identical data.
  - Read ports never stall and never conflict with the write port.
- Storage is a flat register array; read selection is a per-port DEPTH:1 mux followed by an output register. No combinational path from inputs to outputs.
- No X propagation: out-of-range and zero-register reads return defined 0.

Test Plan:
- Reset with reset=0 for 2 cycles, then reset=1, then read all 32 addresses on port 0 -> every rd_data[0]==0; rd_valid[0]==0 during reset and ==1 one cycle after each rd_en.
- Write 64'hDEAD_BEEF_0000_0001 to reg 5; next cycle rd_en=2'b11, rd_addr={5,5} -> both ports return 64'hDEAD_BEEF_0000_0001 after one cycle with rd_valid=2'b11.
- BYPASS=1: reg 7 holds 64'h11; at one edge write 64'h22 to reg 7 and read reg 7 -> rd_data=64'h22. Repeat with BYPASS=0 -> rd_data=64'h11, and the next read returns 64'h22.
- Write 64'hFFFF_FFFF_FFFF_FFFF to reg 31 with ZERO_REG=1, then read reg 31 -> 0 (same edge and later). With ZERO_REG=0 -> all ones.
- DEPTH=20, AW=5: write 64'h5 to addr 25, then read addr 25 -> rd_data=0, rd_valid=1; regs 0-19 unchanged.
- Write reg 3=64'hA, then assert reset=0 at an edge together with wr_en to reg 3 and rd_en -> after reset reg 3 reads 0, rd_valid=0 at the reset edge; hold test: rd_en low for 3 cycles -> rd_data unchanged, rd_valid=0.

Source files
------------

// File: rtl/regfile_nr1w_if.sv
// Register-file access bundle: one write port plus NREAD read ports.
// Latency: n/a (wiring only); the register file adds one cycle on reads.
// Backpressure: none; read and write ports are always accepted.
interface regfile_nr1w_if #(
  parameter int WIDTH = 64,
  parameter int AW    = 5,
  parameter int NREAD = 2
);
  logic                             wr_en;
  logic [AW-1:0]                    wr_addr;
  logic [WIDTH-1:0]                 wr_data;
  logic [NREAD-1:0]                 rd_en;
  logic [NREAD-1:0][AW-1:0]         rd_addr;
  logic [NREAD-1:0][WIDTH-1:0]      rd_data;
  logic [NREAD-1:0]                 rd_valid;

  // Decode stage drives requests and consumes read results.
  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr,
    input  rd_data, rd_valid
  );

  // Register file accepts requests and returns read results.
  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
    output rd_data, rd_valid
  );
endinterface

// File: rtl/regfile_nr1w.sv
// Register file, one write port, NREAD registered read ports, optional zero reg and bypass.
// Latency: reads return data and valid one cycle after rd_en; writes land at the edge.
// Backpressure: none; ports never stall and never conflict.
module regfile_nr1w #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int ZERO_IDX = 31,
  parameter int BYPASS   = 1
) (
  input logic           clk,
  input logic           reset,
  regfile_nr1w_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH itself is representable when DEPTH is a power of two.
  localparam logic [AW:0]   DEPTH_W = DEPTH[AW:0];
  localparam logic [AW-1:0] ZIDX    = ZERO_IDX[AW-1:0];

  logic [WIDTH-1:0]            r_mem [DEPTH];
  logic [NREAD-1:0][WIDTH-1:0] r_rd_data;
  logic [NREAD-1:0]            r_rd_valid;
  logic [NREAD-1:0][WIDTH-1:0] w_rd_sel;
  logic                        w_wr_eff;

  // Decide whether the requested write really updates storage.
  always_comb begin
    w_wr_eff = 1'b0;
    if (bus.wr_en && ({1'b0, bus.wr_addr} < DEPTH_W)) begin
      w_wr_eff = !((ZERO_REG == 1) && (bus.wr_addr == ZIDX));
    end
  end

  // Storage array: cleared by reset, otherwise updated by an effective write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_eff) begin
      r_mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Per-port read select: range and zero-reg checks first, then bypass, then storage.
  always_comb begin
    w_rd_sel = '0;
    for (int p = 0; p < NREAD; p++) begin
      if ({1'b0, bus.rd_addr[p]} >= DEPTH_W) begin
        w_rd_sel[p] = '0;
      end else if ((ZERO_REG == 1) && (bus.rd_addr[p] == ZIDX)) begin
        w_rd_sel[p] = '0;
      end else if ((BYPASS == 1) && w_wr_eff && (bus.wr_addr == bus.rd_addr[p])) begin
        w_rd_sel[p] = bus.wr_data;
      end else begin
        w_rd_sel[p] = r_mem[bus.rd_addr[p]];
      end
    end
  end

  // Output registers: load on rd_en, hold otherwise; valid pulses for one cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rd_data  <= '0;
      r_rd_valid <= '0;
    end else begin
      for (int p = 0; p < NREAD; p++) begin
        r_rd_valid[p] <= bus.rd_en[p];
        if (bus.rd_en[p]) begin
          r_rd_data[p] <= w_rd_sel[p];
        end
      end
    end
  end

  assign bus.rd_data  = r_rd_data;
  assign bus.rd_valid = r_rd_valid;
endmodule

// File: tb/tb_regfile_nr1w.sv
// Directed bench for regfile_nr1w: three instances (default, no-bypass/no-zero, DEPTH=20)
// share one stimulus stream; each check compares against hand-computed values.
// Outputs are sampled 1 time unit after each rising edge.
module tb_regfile_nr1w;
  logic                 clk;
  logic                 reset;
  logic                 wr_en;
  logic [4:0]           wr_addr;
  logic [63:0]          wr_data;
  logic [1:0]           rd_en;
  logic [1:0][4:0]      rd_addr;

  int asserts;
  int fails;

  regfile_nr1w_if #(.WIDTH(64), .AW(5), .NREAD(2)) if_a ();
  regfile_nr1w_if #(.WIDTH(64), .AW(5), .NREAD(2)) if_b ();
  regfile_nr1w_if #(.WIDTH(64), .AW(5), .NREAD(2)) if_c ();

  assign if_a.wr_en = wr_en;  assign if_a.wr_addr = wr_addr;  assign if_a.wr_data = wr_data;
  assign if_a.rd_en = rd_en;  assign if_a.rd_addr = rd_addr;
  assign if_b.wr_en = wr_en;  assign if_b.wr_addr = wr_addr;  assign if_b.wr_data = wr_data;
  assign if_b.rd_en = rd_en;  assign if_b.rd_addr = rd_addr;
  assign if_c.wr_en = wr_en;  assign if_c.wr_addr = wr_addr;  assign if_c.wr_data = wr_data;
  assign if_c.rd_en = rd_en;  assign if_c.rd_addr = rd_addr;

  // Default configuration: zero reg 31, bypass on.
  regfile_nr1w u_dut (.clk(clk), .reset(reset), .bus(if_a));
  // No bypass, no zero register.
  regfile_nr1w #(.BYPASS(0), .ZERO_REG(0)) u_nb (.clk(clk), .reset(reset), .bus(if_b));
  // Non-power-of-two depth; zero register placed at 19.
  regfile_nr1w #(.DEPTH(20), .ZERO_IDX(19)) u_d20 (.clk(clk), .reset(reset), .bus(if_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_en = 2'b00; rd_addr = '0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0; rd_en = 2'b11; wr_en = 1'b1; wr_addr = 5'd1; wr_data = 64'hABCD;
    for (int c = 0; c < 2; c++) begin
      tick();
      asserts++;
      if (if_a.rd_valid !== 2'b00) begin
        fails++; $display("FAIL reset_valid cyc=%0d got=%b exp=00", c, if_a.rd_valid);
      end
      asserts++;
      if (if_a.rd_data !== '0) begin
        fails++; $display("FAIL reset_data cyc=%0d got=%h exp=0", c, if_a.rd_data);
      end
    end
    idle();
    reset = 1'b1;
    for (int i = 0; i < 32; i++) begin
      rd_en = 2'b01; rd_addr[0] = 5'(i);
      tick();
      asserts++;
      if (if_a.rd_data[0] !== 64'h0 || if_a.rd_valid[0] !== 1'b1) begin
        fails++;
        $display("FAIL reset_readall addr=%0d got=%h/%b exp=0/1", i, if_a.rd_data[0], if_a.rd_valid[0]);
      end
    end
    rd_en = 2'b00;
    tick();
    asserts++;
    if (if_a.rd_valid !== 2'b00) begin
      fails++; $display("FAIL valid_drop got=%b exp=00", if_a.rd_valid);
    end
  endtask

  task automatic test_write_read();
    idle();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'hDEAD_BEEF_0000_0001;
    tick();
    idle();
    rd_en = 2'b11; rd_addr[0] = 5'd5; rd_addr[1] = 5'd5;
    tick();
    asserts++;
    if (if_a.rd_data[0] !== 64'hDEAD_BEEF_0000_0001 || if_a.rd_data[1] !== 64'hDEAD_BEEF_0000_0001) begin
      fails++; $display("FAIL wr_rd_both got=%h exp=both DEADBEEF00000001", if_a.rd_data);
    end
    asserts++;
    if (if_a.rd_valid !== 2'b11) begin
      fails++; $display("FAIL wr_rd_valid got=%b exp=11", if_a.rd_valid);
    end
    asserts++;
    if (if_c.rd_data[1] !== 64'hDEAD_BEEF_0000_0001) begin
      fails++; $display("FAIL wr_rd_d20 got=%h exp=DEADBEEF00000001", if_c.rd_data[1]);
    end
  endtask

  task automatic test_bypass();
    idle();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'h11;
    tick();
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'h22;
    rd_en = 2'b01; rd_addr[0] = 5'd7; rd_addr[1] = 5'd5;
    tick();
    asserts++;
    if (if_a.rd_data[0] !== 64'h22) begin
      fails++; $display("FAIL bypass_on got=%h exp=22", if_a.rd_data[0]);
    end
    asserts++;
    if (if_b.rd_data[0] !== 64'h11) begin
      fails++; $display("FAIL bypass_off_old got=%h exp=11", if_b.rd_data[0]);
    end
    idle();
    rd_en = 2'b11; rd_addr[0] = 5'd7; rd_addr[1] = 5'd5;
    tick();
    asserts++;
    if (if_b.rd_data[0] !== 64'h22) begin
      fails++; $display("FAIL bypass_off_next got=%h exp=22", if_b.rd_data[0]);
    end
    asserts++;
    if (if_a.rd_data[0] !== 64'h22 || if_a.rd_data[1] !== 64'hDEAD_BEEF_0000_0001) begin
      fails++; $display("FAIL indep_ports got=%h exp=p1 DEADBEEF00000001 p0 22", if_a.rd_data);
    end
  endtask

  task automatic test_zero_reg();
    idle();
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
    rd_en = 2'b01; rd_addr[0] = 5'd31;
    tick();
    asserts++;
    if (if_a.rd_data[0] !== 64'h0) begin
      fails++; $display("FAIL zero_same_edge got=%h exp=0", if_a.rd_data[0]);
    end
    asserts++;
    if (if_b.rd_data[0] !== 64'h0) begin
      fails++; $display("FAIL nozero_same_edge got=%h exp=0", if_b.rd_data[0]);
    end
    idle();
    rd_en = 2'b01; rd_addr[0] = 5'd31;
    tick();
    asserts++;
    if (if_a.rd_data[0] !== 64'h0) begin
      fails++; $display("FAIL zero_later got=%h exp=0", if_a.rd_data[0]);
    end
    asserts++;
    if (if_b.rd_data[0] !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      fails++; $display("FAIL nozero_later got=%h exp=FFFFFFFFFFFFFFFF", if_b.rd_data[0]);
    end
    asserts++;
    if (if_c.rd_data[0] !== 64'h0 || if_c.rd_valid[0] !== 1'b1) begin
      fails++; $display("FAIL d20_oor31 got=%h/%b exp=0/1", if_c.rd_data[0], if_c.rd_valid[0]);
    end
  endtask

  task automatic test_out_of_range();
    logic [63:0] exp;
    idle();
    wr_en = 1'b1; wr_addr = 5'd25; wr_data = 64'h5;
    tick();
    idle();
    rd_en = 2'b10; rd_addr[1] = 5'd25;
    tick();
    asserts++;
    if (if_c.rd_data[1] !== 64'h0 || if_c.rd_valid !== 2'b10) begin
      fails++; $display("FAIL oor_read got=%h/%b exp=0/10", if_c.rd_data[1], if_c.rd_valid);
    end
    for (int i = 0; i < 20; i++) begin
      exp = (i == 5) ? 64'hDEAD_BEEF_0000_0001 : (i == 7) ? 64'h22 : 64'h0;
      rd_en = 2'b01; rd_addr[0] = 5'(i);
      tick();
      asserts++;
      if (if_c.rd_data[0] !== exp) begin
        fails++; $display("FAIL oor_unchanged reg=%0d got=%h exp=%h", i, if_c.rd_data[0], exp);
      end
    end
  endtask

  task automatic test_reset_override();
    idle();
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'hA;
    tick();
    reset = 1'b0;
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'hB;
    rd_en = 2'b11; rd_addr[0] = 5'd3; rd_addr[1] = 5'd5;
    tick();
    asserts++;
    if (if_a.rd_valid !== 2'b00 || if_a.rd_data !== '0) begin
      fails++; $display("FAIL rst_edge got=%h/%b exp=0/00", if_a.rd_data, if_a.rd_valid);
    end
    reset = 1'b1;
    idle();
    rd_en = 2'b11; rd_addr[0] = 5'd3; rd_addr[1] = 5'd5;
    tick();
    asserts++;
    if (if_a.rd_data[0] !== 64'h0 || if_a.rd_data[1] !== 64'h0 || if_a.rd_valid !== 2'b11) begin
      fails++; $display("FAIL rst_cleared got=%h/%b exp=0/11", if_a.rd_data, if_a.rd_valid);
    end
  endtask

  task automatic test_hold();
    idle();
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 64'h44;
    tick();
    idle();
    rd_en = 2'b01; rd_addr[0] = 5'd4;
    tick();
    asserts++;
    if (if_a.rd_data[0] !== 64'h44) begin
      fails++; $display("FAIL hold_setup got=%h exp=44", if_a.rd_data[0]);
    end
    idle();
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 64'h55; rd_addr[0] = 5'd4;
    for (int c = 0; c < 3; c++) begin
      tick();
      asserts++;
      if (if_a.rd_data[0] !== 64'h44 || if_a.rd_valid !== 2'b00) begin
        fails++; $display("FAIL hold cyc=%0d got=%h/%b exp=44/00", c, if_a.rd_data[0], if_a.rd_valid);
      end
    end
  endtask

  initial begin
    asserts = 0;
    fails   = 0;
    reset   = 1'b0;
    idle();
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_reg();
    test_out_of_range();
    test_reset_override();
    test_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
